// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: immediate format coding (matches the decoder's ImmSrc)
// and the canonical NOP.
package riscv_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // True when the sign-extended immediate cannot be encoded in the given format.
  function automatic logic imm_unrepresentable(fmt_e fmt, logic [31:0] imm);
    logic bad;
    bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: bad = !(&imm[31:11] || ~|imm[31:11]);
      FMT_B:        bad = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      FMT_J:        bad = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: places opcode, registers, funct3 and immediate bits
// into a 32-bit I/S/B/J instruction word.
module imm_pack
  import riscv_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] instr
);

  always_comb begin
    instr = '0;
    unique case (fmt)
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder with address tagging.
// Define IMM_RANGE_CHECK_EN to replace unencodable immediates with a flagged NOP.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  logic        s1_valid, s2_valid;
  fmt_e        s1_fmt;
  logic [6:0]  s1_op;
  logic [2:0]  s1_f3;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [20:0] s1_imm;
  logic [31:0] packed_instr, next_instr, s2_instr, addr_q;
  logic        s2_ready, in_fire, s1_move, out_fire;

  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign in_ready = !(s1_valid && s2_valid && !out_ready);
  assign s2_ready = !s2_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s1_move  = s1_valid && s2_ready;
  assign out_fire = s2_valid && out_ready;

  imm_pack u_imm_pack (
    .fmt    (s1_fmt),
    .opcode (s1_op),
    .funct3 (s1_f3),
    .rd     (s1_rd),
    .rs1    (s1_rs1),
    .rs2    (s1_rs2),
    .imm    (s1_imm),
    .instr  (packed_instr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_instr <= '0;
      addr_q   <= BASE_ADDR;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_fire) begin
        s1_fmt <= fmt_e'(in_fmt);
        s1_op  <= in_opcode;
        s1_f3  <= in_funct3;
        s1_rd  <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_imm <= in_imm[20:0];
      end
      if (s2_ready) s2_valid <= s1_valid;
      if (s1_move)  s2_instr <= next_instr;
      if (out_fire) addr_q   <= addr_q + 32'd4;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic       s1_bad, s2_err;
  logic [7:0] cnt_q;

  assign next_instr = s1_bad ? INSTR_NOP : packed_instr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_err <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (in_fire) s1_bad <= imm_unrepresentable(fmt_e'(in_fmt), in_imm);
      if (s1_move) s2_err <= s1_bad;
      if (out_fire && s2_err && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign out_err = s2_err;
  assign err_cnt = cnt_q;
`else
  // Upper immediate bits only matter to the range check; truncate silently here.
  logic [10:0] unused_imm_hi;
  assign unused_imm_hi = in_imm[31:21];
  assign next_instr    = packed_instr;
  assign out_err       = 1'b0;
`endif

  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_addr  = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder; honours IMM_RANGE_CHECK_EN like the design.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;  // wraps after four words
  localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RNG = 1'b1;
`else
  localparam bit RNG = 1'b0;
`endif

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr, out_addr;
`ifdef IMM_RANGE_CHECK_EN
  logic [7:0]  err_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr;
  int          exp_errcnt;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err)
`ifdef IMM_RANGE_CHECK_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input word_t w);
    in_fmt = w.fmt; in_opcode = w.op; in_funct3 = w.f3;
    in_rd = w.rd; in_rs1 = w.rs1; in_rs2 = w.rs2; in_imm = w.imm;
  endtask

  function automatic word_t mk(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm);
    word_t w;
    w.fmt = fmt; w.op = op; w.f3 = f3; w.rd = rd; w.rs1 = rs1; w.rs2 = rs2; w.imm = imm;
    return w;
  endfunction

  // Representability from the numeric range of each format's immediate.
  function automatic bit is_bad(input word_t w);
    int v;
    v = $signed(w.imm);
    if (!RNG) return 1'b0;
    case (w.fmt)
      2'd0, 2'd1: return v < -2048 || v > 2047;
      2'd2:       return v < -4096 || v > 4095 || w.imm[0];
      default:    return v < -(1 << 20) || v > (1 << 20) - 1 || w.imm[0];
    endcase
  endfunction

  // Standard RISC-V immediate decoder (the inverse view of the encoding).
  function automatic logic [31:0] dec_imm(input logic [1:0] fmt, input logic [31:0] i);
    case (fmt)
      2'd0:    return {{20{i[31]}}, i[31:20]};
      2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic word_t rand_word();
    word_t w;
    w = mk(2'($urandom_range(0, 3)), 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 32'd0);
    if (RNG && $urandom_range(0, 4) == 0) w.imm = $urandom;
    else begin
      case (w.fmt)
        2'd0, 2'd1: w.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        2'd2:       w.imm = 32'(2 * int'($urandom_range(0, 4095)) - 4096);
        default:    w.imm = 32'(2 * int'($urandom_range(0, (1 << 20) - 1)) - (1 << 20));
      endcase
    end
    return w;
  endfunction

  task automatic test_reset;
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    drive(mk(2'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0));
    step; step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", out_err); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL rst_instr: got %h want 0", out_instr); end
    checks++; if (out_addr !== BASE) begin errors++; $display("FAIL rst_addr: got %h want %h", out_addr, BASE); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
`ifdef IMM_RANGE_CHECK_EN
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
`endif
    rst_n = 1'b1;
    step;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    exp_addr = BASE; exp_errcnt = 0;
  endtask

  task automatic test_directed;
    word_t       vec[6];
    logic [31:0] want[6];
    logic        werr[6];
    vec[0] = mk(2'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd31, 32'hFFFF_FFFF);   want[0] = 32'hFFF3_0293;
    vec[1] = mk(2'd2, 7'h63, 3'd0, 5'd31, 5'd1, 5'd2, 32'd8);           want[1] = 32'h0020_8463;
    vec[2] = mk(2'd3, 7'h6F, 3'd5, 5'd1, 5'd7, 5'd9, 32'd2048);         want[2] = 32'h0010_00EF;
    vec[3] = mk(2'd1, 7'h23, 3'd2, 5'd17, 5'd2, 5'd3, 32'd12);          want[3] = 32'h0031_2623;
    vec[4] = mk(2'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
    vec[5] = mk(2'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd7);
    for (int i = 0; i < 6; i++) werr[i] = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    want[4] = NOP; werr[4] = 1'b1;
    want[5] = NOP; werr[5] = 1'b1;
`else
    want[4] = 32'h8000_0013;
    want[5] = 32'h0000_0363;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vec[i]); in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready); end
      step; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_early[%0d]: got %b want 0", i, out_valid); end
      step;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_instr !== want[i]) begin errors++; $display("FAIL dir_instr[%0d]: got %h want %h", i, out_instr, want[i]); end
      checks++; if (out_addr !== exp_addr) begin errors++; $display("FAIL dir_addr[%0d]: got %h want %h", i, out_addr, exp_addr); end
      checks++; if (out_err !== werr[i]) begin errors++; $display("FAIL dir_err[%0d]: got %b want %b", i, out_err, werr[i]); end
      step;
      exp_addr += 32'd4;
      if (werr[i]) exp_errcnt++;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_drain[%0d]: got %b want 0", i, out_valid); end
`ifdef IMM_RANGE_CHECK_EN
      checks++;
      if (err_cnt !== 8'(exp_errcnt)) begin errors++; $display("FAIL dir_err_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_errcnt); end
`endif
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] want[3];
    logic [31:0] cap_i[3], cap_a[3];
    int          n;
    bit          acc;
    want[0] = 32'h0010_0093; want[1] = 32'h0020_0113; want[2] = 32'h0030_0193;
    for (int k = 0; k < 3; k++) begin cap_i[k] = 'x; cap_a[k] = 'x; end
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(mk(2'd0, 7'h13, 3'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k + 1)));
      if (k < 2) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept[%0d]: got %b want 1", k, in_ready); end
        step;
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full[%0d]: got %b want 0", k, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_instr !== want[0]) begin errors++; $display("FAIL bp_hold_instr[%0d]: got %h want %h", k, out_instr, want[0]); end
      checks++; if (out_addr !== exp_addr) begin errors++; $display("FAIL bp_hold_addr[%0d]: got %h want %h", k, out_addr, exp_addr); end
      step;
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      if (out_valid) begin cap_i[n] = out_instr; cap_a[n] = out_addr; n++; end
      acc = in_valid && in_ready;
      step;
      if (acc) in_valid = 1'b0;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", n); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (cap_i[k] !== want[k]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, cap_i[k], want[k]); end
      checks++;
      if (cap_a[k] !== exp_addr + 32'(4 * k)) begin errors++; $display("FAIL bp_addr[%0d]: got %h want %h", k, cap_a[k], exp_addr + 32'(4 * k)); end
    end
    exp_addr += 32'd12;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit seen;
    out_ready = 1'b0; in_valid = 1'b1;
    drive(mk(2'd0, 7'h13, 3'd0, 5'd9, 5'd0, 5'd0, 32'd9));
    step; step;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_full: got %b want 0", in_ready); end
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    exp_addr = BASE; exp_errcnt = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    checks++; if (out_addr !== BASE) begin errors++; $display("FAIL rm_addr: got %h want %h", out_addr, BASE); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
`ifdef IMM_RANGE_CHECK_EN
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rm_err_cnt: got %0d want 0", err_cnt); end
`endif
    out_ready = 1'b1; seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen = 1'b1;
      step;
    end
    checks++; if (seen) begin errors++; $display("FAIL rm_ghost: got emitted word want none"); end
    drive(mk(2'd0, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 32'd5)); in_valid = 1'b1;
    step; in_valid = 1'b0;
    step;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_next_valid: got %b want 1", out_valid); end
    checks++; if (out_instr !== 32'h0050_0293) begin errors++; $display("FAIL rm_next_instr: got %h want 00500293", out_instr); end
    checks++; if (out_addr !== BASE) begin errors++; $display("FAIL rm_next_addr: got %h want %h", out_addr, BASE); end
    step;
    exp_addr += 32'd4;
  endtask

  task automatic test_random(input int n_words);
    word_t q[$];
    int    received, cyc;
    received = 0; cyc = 0;
    fork
      begin : driver
        for (int i = 0; i < n_words; i++) begin
          word_t w;
          bit    acc;
          int    tries;
          while ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; step; end
          w = rand_word();
          drive(w); in_valid = 1'b1;
          tries = 0;
          do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) q.push_back(w);
            step;
            tries++;
          end while (!acc && tries < 1000);
        end
        in_valid = 1'b0;
      end
      begin : monitor
        bit          stalled;
        logic [31:0] p_instr, p_addr;
        logic        p_err;
        stalled = 1'b0;
        while (received < n_words && cyc < 20000) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          cyc++;
          if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_instr !== p_instr || out_addr !== p_addr || out_err !== p_err) begin
              errors++;
              $display("FAIL rnd_stall: got v=%b %h @%h e=%b want v=1 %h @%h e=%b",
                       out_valid, out_instr, out_addr, out_err, p_instr, p_addr, p_err);
            end
          end
          if (out_valid && out_ready) begin
            received++;
            checks++;
            if (q.size() == 0) begin
              errors++; $display("FAIL rnd_extra: got %h want no word", out_instr);
            end else begin
              word_t w;
              bit    bad;
              logic [31:0] got_imm;
              w = q.pop_front();
              bad = is_bad(w);
              got_imm = dec_imm(w.fmt, out_instr);
              if (out_addr !== exp_addr) begin
                errors++; $display("FAIL rnd_addr: got %h want %h", out_addr, exp_addr);
              end else if (bad && (out_instr !== NOP || out_err !== 1'b1)) begin
                errors++; $display("FAIL rnd_reject: got %h e=%b want %h e=1", out_instr, out_err, NOP);
              end else if (!bad && (out_err !== 1'b0 || out_instr[6:0] !== w.op || got_imm !== w.imm
                         || (w.fmt != 2'd1 && w.fmt != 2'd2 && out_instr[11:7] !== w.rd)
                         || (w.fmt != 2'd3 && out_instr[19:15] !== w.rs1)
                         || (w.fmt != 2'd3 && out_instr[14:12] !== w.f3)
                         || ((w.fmt == 2'd1 || w.fmt == 2'd2) && out_instr[24:20] !== w.rs2))) begin
                errors++;
                $display("FAIL rnd_fields: got %h e=%b imm=%h want fmt=%0d op=%h f3=%0d rd=%0d rs1=%0d rs2=%0d imm=%h",
                         out_instr, out_err, got_imm, w.fmt, w.op, w.f3, w.rd, w.rs1, w.rs2, w.imm);
              end
              if (bad && exp_errcnt < 255) exp_errcnt++;
            end
            exp_addr += 32'd4;
          end
          stalled = out_valid && !out_ready;
          p_instr = out_instr; p_addr = out_addr; p_err = out_err;
        end
      end
    join
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rnd_timeout: got %0d words want %0d", received, n_words); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d want 0", q.size()); end
`ifdef IMM_RANGE_CHECK_EN
    checks++; if (err_cnt !== 8'(exp_errcnt)) begin errors++; $display("FAIL rnd_err_cnt: got %0d want %0d", err_cnt, exp_errcnt); end
`endif
    out_ready = 1'b1;
    step; step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle: got %b want 0", out_valid); end
  endtask

`ifdef IMM_RANGE_CHECK_EN
  task automatic test_saturate;
    int n_in, n_out, n_err, cyc;
    n_in = 0; n_out = 0; n_err = 0; cyc = 0;
    out_ready = 1'b1;
    drive(mk(2'd0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'd4096));
    while (n_out < 260 && cyc < 2000) begin
      in_valid = (n_in < 260);
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) n_in++;
      if (out_valid && out_ready) begin
        n_out++;
        if (out_err === 1'b1 && out_instr === NOP) n_err++;
      end
      step;
    end
    in_valid = 1'b0;
    exp_addr += 32'(4 * n_out);
    checks++; if (n_err != 260) begin errors++; $display("FAIL sat_words: got %0d want 260", n_err); end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_random(400);
`ifdef IMM_RANGE_CHECK_EN
    test_saturate;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the address tagged to the first word emitted after reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have input-side ports: in_valid in 1; in_ready out 1; in_fmt in 2 (00 I, 01 S, 10 B, 11 J); in_opcode in 7; in_funct3 in 3; in_rd in 5; in_rs1 in 5; in_rs2 in 5; in_imm in 32 (sign-extended immediate value).
REQ-004 SHALL have output-side ports: out_valid out 1; out_ready in 1; out_instr out 32; out_addr out 32; out_err out 1.
REQ-005 SHALL have port err_cnt out 8, the saturating count of rejected words (present only per REQ-019).

Function
REQ-006 SHALL encode fields as follows. I: {imm[11:0],rs1,f3,rd,op}. S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}. B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}. J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-007 SHALL ignore unused fields per format: rs2 for I and J; rd for S and B; rs1 and f3 for J.
REQ-008 SHALL use a 2-stage pipeline: S1 registers the inputs and the range-check result; S2 holds the encoded output register.
REQ-009 SHALL present a word on out_valid/out_instr exactly 2 cycles after in_valid&&in_ready when no stall occurs.
REQ-010 SHALL follow valid/ready rules: a transfer occurs on a cycle with valid&&ready; out_valid SHALL NOT drop, and out_instr/out_addr/out_err SHALL NOT change, while out_valid&&!out_ready.
REQ-011 SHALL drive in_ready = !(s1_valid && s2_valid && !out_ready), giving a capacity of 2 words, no bubbles under continuous flow, and no combinational path from in_valid to in_ready.
REQ-012 SHALL preserve word order and SHALL never drop or duplicate a word.
REQ-013 SHALL tag words with out_addr starting at BASE_ADDR and incrementing by 4 on each output transfer, wrapping modulo 2^32.
REQ-014 SHALL continue passing words through unchanged when simultaneous input and output transfers occur in the same cycle.

Reset
REQ-015 SHALL, on a rising edge with rst_n=0, clear s1_valid and s2_valid and load the address counter with BASE_ADDR; err_cnt SHALL become 0.
REQ-016 SHALL, during reset, hold out_valid=0, out_err=0, out_instr=0 and out_addr=BASE_ADDR; in_ready SHALL be 1 during and after reset.
REQ-017 SHALL discard in-flight words when reset is asserted mid-operation; none SHALL be emitted afterwards.

Configuration
REQ-018 SHALL gate range checking on macro IMM_RANGE_CHECK_EN.
REQ-019 SHALL, when IMM_RANGE_CHECK_EN is defined, flag a word unrepresentable if any of these hold: for I/S, imm[31:11] is not all-equal; for B, imm[31:12] is not all-equal or imm[0]=1; for J, imm[31:20] is not all-equal or imm[0]=1.
REQ-020 SHALL, for a flagged word, emit out_instr=32'h0000_0013 (NOP) with out_err=1, still consume an address, and increment err_cnt on output transfer, saturating at 255.
REQ-021 SHALL, when IMM_RANGE_CHECK_EN is undefined, tie out_err to 0, truncate imm silently, and omit the err_cnt port.

Structure
REQ-022 SHALL place in shared package riscv_pkg: the format enum (FMT_I/S/B/J = 00/01/10/11, identical to the existing decoder's ImmSrc coding) and the constant INSTR_NOP=32'h0000_0013.
REQ-023 SHALL implement the field packing of REQ-006 as one combinational sub-module, imm_pack, instantiated between S1 and S2.

Verification
REQ-024 SHALL check an I-type word: fmt=I, op=7'h13, rd=5, rs1=6, f3=0, imm=-1 -> out_instr=32'hFFF3_0293, out_addr=BASE_ADDR, valid 2 cycles later.
REQ-025 SHALL check a B-type word: fmt=B, op=7'h63, rs1=1, rs2=2, f3=0, imm=8 -> 32'h0020_8463.
REQ-026 SHALL check a J-type word: fmt=J, op=7'h6F, rd=1, imm=2048 -> 32'h0010_00EF; the bench SHALL also run random in-range words round-tripped through the existing immediate decoder and require equality with in_imm.
REQ-027 SHALL check rejection: with the macro, fmt=I imm=2048 -> out_instr=32'h0000_0013, out_err=1, err_cnt=1; fmt=B imm=7 -> err_cnt=2. Without the macro, the same I-type stimulus -> 32'h8000_0013 (truncated), out_err=0.
REQ-028 SHALL check backpressure: hold out_ready=0 while offering 3 words -> in_ready=0 after 2 are accepted; on release, the 3 words emerge in order at addresses 0, 4, 8 with stable outputs during the stall.
REQ-029 SHALL check reset mid-operation: rst_n=0 for one edge with S1 and S2 full -> next cycle out_valid=0, out_addr=BASE_ADDR, err_cnt=0, and the next accepted word has out_addr=BASE_ADDR.
